// File: rtl/fitness_eval_arbiter.sv
// Round-robin arbiter that time-shares one fitness evaluator between NUM_REQ requesters,
// capturing the winner's chromosome and returning the result (or a timeout) to that requester.
module fitness_eval_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int CHROMOSOME_WIDTH = 8,
  parameter int FITNESS_WIDTH    = 10,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ*CHROMOSOME_WIDTH-1:0]   req_chromosome,
  output logic [NUM_REQ-1:0]                    grant,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [FITNESS_WIDTH-1:0]              rsp_fitness,
  output logic                                  rsp_timeout,
  output logic                                  eval_start,
  output logic [CHROMOSOME_WIDTH-1:0]           eval_chromosome,
  input  logic                                  eval_done,
  input  logic [FITNESS_WIDTH-1:0]              eval_fitness,
  output logic                                  busy,
  output logic [15:0]                           eval_count,
  output logic [1:0]                            state_dbg
);

  // Handshakes: req is a level held by the requester until it sees its one-cycle grant pulse;
  // rsp_valid is a one-cycle pulse (qualified by rsp_timeout); eval_start is a level held
  // until eval_done is sampled in BUSY or the timeout fires.

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                      state;
  logic [PW-1:0]               ptr;
  logic [PW-1:0]               win_q;
  logic [TW-1:0]               tcnt;

  logic                        any_req;
  logic [PW-1:0]               winner;
  logic [PW-1:0]               ptr_next;
  logic [CHROMOSOME_WIDTH-1:0] win_chrom;

  // Rotating priority: first scan bits at or above ptr, then wrap to the bits below it.
  always_comb begin
    any_req   = 1'b0;
    winner    = '0;
    win_chrom = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req[i] && (i >= int'(ptr))) begin
        any_req   = 1'b1;
        winner    = PW'(i);
        win_chrom = req_chromosome[i*CHROMOSOME_WIDTH +: CHROMOSOME_WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req[i]) begin
        any_req   = 1'b1;
        winner    = PW'(i);
        win_chrom = req_chromosome[i*CHROMOSOME_WIDTH +: CHROMOSOME_WIDTH];
      end
    end
  end

  always_comb begin
    if (int'(winner) == NUM_REQ - 1) ptr_next = '0;
    else                             ptr_next = winner + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      win_q           <= '0;
      tcnt            <= '0;
      grant           <= '0;
      rsp_valid       <= '0;
      rsp_fitness     <= '0;
      rsp_timeout     <= 1'b0;
      eval_start      <= 1'b0;
      eval_chromosome <= '0;
      eval_count      <= '0;
    end else begin
      grant     <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state           <= BUSY;
            grant           <= NUM_REQ'(1) << winner;
            eval_start      <= 1'b1;
            eval_chromosome <= win_chrom;
            win_q           <= winner;
            ptr             <= ptr_next;
            tcnt            <= '0;
          end
        end
        BUSY: begin
          // A done on the last allowed cycle beats the timeout.
          if (eval_done) begin
            state       <= RESP;
            rsp_valid   <= NUM_REQ'(1) << win_q;
            rsp_fitness <= eval_fitness;
            rsp_timeout <= 1'b0;
            eval_start  <= 1'b0;
            if (eval_count != 16'hFFFF) eval_count <= eval_count + 16'd1;
          end else if (tcnt == TO_LAST) begin
            state       <= RESP;
            rsp_valid   <= NUM_REQ'(1) << win_q;
            rsp_fitness <= '0;
            rsp_timeout <= 1'b1;
            eval_start  <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_fitness_eval_arbiter.sv
// Bench for fitness_eval_arbiter: transaction-level round-robin model feeding an expected
// queue, a monitor that pops and compares each response, and a behavioural evaluator.
module tb_fitness_eval_arbiter;

  localparam int NR = 4;
  localparam int CW = 8;
  localparam int FW = 10;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*CW-1:0]  req_chromosome;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     rsp_valid;
  logic [FW-1:0]     rsp_fitness;
  logic              rsp_timeout;
  logic              eval_start;
  logic [CW-1:0]     eval_chromosome;
  logic              eval_done;
  logic [FW-1:0]     eval_fitness;
  logic              busy;
  logic [15:0]       eval_count;
  logic [1:0]        state_dbg;

  fitness_eval_arbiter #(
    .NUM_REQ(NR), .CHROMOSOME_WIDTH(CW), .FITNESS_WIDTH(FW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_chromosome(req_chromosome),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_fitness(rsp_fitness),
    .rsp_timeout(rsp_timeout), .eval_start(eval_start), .eval_chromosome(eval_chromosome),
    .eval_done(eval_done), .eval_fitness(eval_fitness), .busy(busy),
    .eval_count(eval_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared bench state ----------------
  typedef struct packed {
    logic [31:0]   g_edge;
    logic [31:0]   r_edge;
    logic [1:0]    w;
    logic [CW-1:0] chrom;
    logic [FW-1:0] fit;
    logic          tmo;
    logic [15:0]   cnt;
  } exp_t;
  localparam int EW = $bits(exp_t);

  typedef struct packed {
    logic [31:0] g_edge;
    logic [1:0]  w;
  } gexp_t;

  logic [EW-1:0] exp_q[$];
  gexp_t         gexp_q[$];
  int            grant_log[$];

  logic [CW-1:0] chrom_v[NR];
  int            pending[NR];
  int            lat_fixed = -1;
  bit            force_fit = 1'b0;
  logic [FW-1:0] force_val = '0;
  bit            ev_rand   = 1'b1;

  int            edge_no   = 0;
  int            free_at   = 0;
  int            mptr      = 0;
  int            mcount    = 0;
  bit            cur_act   = 1'b0;
  int            cur_g     = 0;
  int            cur_n     = 0;
  int            cur_lat   = 0;
  logic [CW-1:0] cur_chrom = '0;

  int compared   = 0;
  int mismatched = 0;

  always_comb begin
    req_chromosome = '0;
    for (int i = 0; i < NR; i++) req_chromosome[i*CW +: CW] = chrom_v[i];
  end

  function automatic logic [FW-1:0] fit_fn(input logic [CW-1:0] c);
    return {c, 2'b01} ^ 10'h155;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({grant, rsp_valid, rsp_fitness, rsp_timeout, eval_start,
                eval_chromosome, busy, eval_count, state_dbg});
  endfunction

  // ---------------- reference model + scoreboard monitor ----------------
  initial begin : scoreboard
    exp_t  e;
    gexp_t g;
    int    w, lat, n, low_cnt;
    bit    tmo, hit, prev_start, had_eval, in_busy, in_start;
    logic [NR-1:0] exp_v;
    low_cnt = 0; prev_start = 0; had_eval = 0;
    forever begin
      @(posedge clk);
      edge_no++;
      if (rst) begin
        exp_q.delete(); gexp_q.delete();
        free_at = 0; mptr = 0; mcount = 0; cur_act = 1'b0;
      end else if (edge_no >= free_at && req != '0) begin
        w = -1;
        for (int k = 0; k < NR; k++)
          if (w < 0 && req[(mptr + k) % NR]) w = (mptr + k) % NR;
        if (lat_fixed >= 0) lat = lat_fixed;
        else lat = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 8));
        tmo = (lat == 0) || (lat > TO);
        n   = tmo ? TO : lat;
        if (!tmo && mcount < 65535) mcount++;
        e.g_edge = edge_no;
        e.r_edge = edge_no + n;
        e.w      = w[1:0];
        e.chrom  = chrom_v[w];
        e.fit    = tmo ? '0 : (force_fit ? force_val : fit_fn(chrom_v[w]));
        e.tmo    = tmo;
        e.cnt    = 16'(mcount);
        exp_q.push_back(e);
        g.g_edge = edge_no; g.w = w[1:0];
        gexp_q.push_back(g);
        cur_act = 1'b1; cur_g = edge_no; cur_n = n; cur_lat = lat; cur_chrom = chrom_v[w];
        free_at = edge_no + n + 2;
        mptr    = (w + 1) % NR;
      end

      #1;
      if (rst) begin
        prev_start = 0; had_eval = 0; low_cnt = 0;
      end else begin
        hit = 0; exp_v = '0;
        if (gexp_q.size() > 0 && gexp_q[0].g_edge == edge_no) begin
          hit = 1; exp_v = NR'(1) << gexp_q[0].w;
        end
        if (hit || grant != '0) begin
          chk("grant", grant, exp_v);
          if (hit) void'(gexp_q.pop_front());
        end
        for (int i = 0; i < NR; i++) if (grant[i]) grant_log.push_back(i);

        hit = 0; exp_v = '0;
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (e.r_edge == edge_no) begin hit = 1; exp_v = NR'(1) << e.w; end
        end
        if (hit || rsp_valid != '0) begin
          chk("rsp_valid", rsp_valid, exp_v);
          if (hit) begin
            chk("rsp_fitness", rsp_fitness, e.fit);
            chk("rsp_timeout", rsp_timeout, e.tmo);
            chk("eval_count", eval_count, e.cnt);
            void'(exp_q.pop_front());
          end
        end

        in_busy  = cur_act && edge_no >= cur_g && edge_no <= cur_g + cur_n;
        in_start = cur_act && edge_no >= cur_g && edge_no <  cur_g + cur_n;
        chk("busy", busy, in_busy);
        chk("eval_start", eval_start, in_start);
        if (in_start) chk("eval_chromosome", eval_chromosome, cur_chrom);

        if (eval_start && !prev_start) begin
          if (had_eval) chk("start_gap", low_cnt >= 2, 1);
          had_eval = 1;
        end
        if (eval_start) low_cnt = 0; else low_cnt++;
        prev_start = eval_start;
      end
    end
  end

  // ---------------- behavioural evaluator (noise on eval_done when idle) ----------------
  initial begin : evaluator
    int bcnt;
    bcnt = 0; eval_done = 1'b0; eval_fitness = '0;
    forever begin
      @(negedge clk);
      if (ev_rand) begin
        eval_done = 1'($urandom); eval_fitness = FW'($urandom); bcnt = 0;
      end else if (eval_start) begin
        bcnt++;
        eval_done    = (cur_lat != 0) && (bcnt == cur_lat);
        eval_fitness = force_fit ? force_val : fit_fn(eval_chromosome);
      end else begin
        bcnt = 0;
        eval_done    = ($urandom_range(0, 3) == 0);
        eval_fitness = FW'($urandom);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (grant[i]) begin
        req[i] = 1'b0;
        pending[i]--;
        chrom_v[i] = CW'($urandom);
      end else begin
        req[i] = (pending[i] > 0);
      end
    end
  endtask

  function automatic int work_left();
    int s;
    s = exp_q.size() + gexp_q.size();
    for (int i = 0; i < NR; i++) if (pending[i] > 0) s += pending[i];
    return s;
  endfunction

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (work_left() != 0 && c < budget) begin step(); c++; end
    chk("wait_idle", work_left(), 0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1; req = '0;
    for (int i = 0; i < NR; i++) pending[i] = 0;
    @(negedge clk); #1 rst = 1'b0;
  endtask

  function automatic int log_at(input int idx);
    return (idx < grant_log.size()) ? grant_log[idx] : -1;
  endfunction

  // ---------------- test sequence ----------------
  initial begin : main
    int base;
    int fair_order[6];
    bit got;
    fair_order = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; req = '0;
    for (int i = 0; i < NR; i++) begin pending[i] = 0; chrom_v[i] = '0; end

    // reset with random inputs
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = NR'($urandom);
      for (int i = 0; i < NR; i++) chrom_v[i] = CW'($urandom);
      @(posedge clk); #1;
      chk("reset_outputs", outs_vec(), 64'd0);
    end
    @(negedge clk); #1 rst = 1'b0; req = '0; ev_rand = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_outputs", outs_vec(), 64'd0);
    end

    // single request
    lat_fixed = 3; force_fit = 1'b1; force_val = 10'h12C;
    chrom_v[2] = 8'hA5; pending[2] = 1;
    wait_idle(200);
    force_fit = 1'b0;
    chk("single_count", eval_count, 1);
    chk("single_winner", log_at(grant_log.size() - 1), 2);

    // fairness from ptr = 0
    do_reset();
    lat_fixed = 2;
    for (int i = 0; i < NR; i++) chrom_v[i] = CW'($urandom);
    pending[0] = 2; pending[1] = 2; pending[2] = 1; pending[3] = 1;
    base = grant_log.size();
    wait_idle(300);
    chk("fair_len", grant_log.size() - base, 6);
    for (int k = 0; k < 6; k++) chk("fair_order", log_at(base + k), fair_order[k]);
    chk("fair_count", eval_count, 6);

    // timeout, then a normal request
    lat_fixed = 0; pending[1] = 1;
    wait_idle(300);
    chk("timeout_count", eval_count, 6);
    lat_fixed = 4; pending[1] = 1;
    wait_idle(200);
    chk("after_timeout_count", eval_count, 7);

    // done on the last BUSY cycle wins; one cycle later is a timeout
    lat_fixed = 64; force_fit = 1'b1; force_val = 10'h3FF; pending[0] = 1;
    wait_idle(300);
    force_fit = 1'b0;
    chk("boundary_count", eval_count, 8);
    lat_fixed = 65; pending[2] = 1;
    wait_idle(300);
    chk("past_boundary_count", eval_count, 8);

    // reset on the 2nd BUSY cycle, then simultaneous requests 1 and 3
    lat_fixed = 10; pending[3] = 1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin step(); got = grant[3]; end
    chk("mid_busy_grant_seen", got, 1);
    @(negedge clk); #1 rst = 1'b1; req = '0;
    for (int i = 0; i < NR; i++) pending[i] = 0;
    @(negedge clk); #1 rst = 1'b0;
    pending[1] = 1; pending[3] = 1;
    base = grant_log.size();
    wait_idle(300);
    chk("post_reset_first", log_at(base), 1);
    chk("post_reset_second", log_at(base + 1), 3);
    chk("post_reset_count", eval_count, 2);

    // randomized traffic
    lat_fixed = -1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NR; i++) begin
        pending[i] = $urandom_range(0, 2);
        chrom_v[i] = CW'($urandom);
      end
      wait_idle(1500);
    end

    chk("exp_q_drained", exp_q.size(), 0);
    chk("grant_q_drained", gexp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
